// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } req_id_t;

   // Bit positions inside the status word
   localparam int unsigned ST_BUS_ERR    = 3;
   localparam int unsigned ST_PROTO_ERR  = 2;
   localparam int unsigned ST_LAST_GRANT = 1;
   localparam int unsigned ST_ERR_PULSE  = 0;

   // Bit positions inside the one-hot grant vector
   localparam int unsigned GNT_FETCH = 0;
   localparam int unsigned GNT_LOAD  = 1;
   localparam int unsigned GNT_STORE = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: STORE > LOAD > fetch, unless fetch has
// waited through a full execute streak, in which case fetch wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       if_req,
   input  logic       ld_req,
   input  logic       st_req,
   input  logic       streak_full,
   output logic [2:0] grant
);

   // Priority encode with the anti-starvation override taking precedence
   always_comb begin
      grant = '0;
      if (if_req && streak_full) begin
         grant[GNT_FETCH] = 1'b1;
      end else if (st_req) begin
         grant[GNT_STORE] = 1'b1;
      end else if (ld_req) begin
         grant[GNT_LOAD] = 1'b1;
      end else if (if_req) begin
         grant[GNT_FETCH] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared between instruction fetch and execute
// LOAD/STORE; one transaction in flight, with timeout and sticky status.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 8,
   parameter int unsigned DW         = 16,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned MAX_STREAK = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_data,
   output logic          if_ack,
   input  logic          ex_rd_req,
   input  logic          ex_wr_req,
   input  logic [AW-1:0] ex_addr,
   input  logic [DW-1:0] ex_wdata,
   output logic [DW-1:0] ex_rdata,
   output logic          ex_value_ready,
   output logic          ex_wr_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   input  logic          status_clr,
   output logic          busy,
   output logic [3:0]    status
);

   localparam int unsigned SW = $clog2(MAX_STREAK + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_t        state, state_nx;
   req_id_t       rid;
   logic [SW-1:0] streak;
   logic [TW-1:0] tcnt;
   logic [2:0]    grant;
   logic          streak_full;
   logic          take_grant;
   logic          finish;
   logic          abort;
   logic          proto_set;
   logic          bus_err, proto_err, last_grant, err_pulse;
   logic [DW-1:0] rsp_data;

   assign streak_full = (streak == SW'(MAX_STREAK));

   mem_arb_pick u_pick (
      .if_req      (if_req),
      .ld_req      (ex_rd_req),
      .st_req      (ex_wr_req),
      .streak_full (streak_full),
      .grant       (grant)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and transaction events
   always_comb begin
      state_nx   = state;
      take_grant = 1'b0;
      finish     = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (|grant) begin
               take_grant = 1'b1;
               state_nx   = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               finish   = 1'b1;
               state_nx = DONE;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               abort    = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign rsp_data  = abort ? '0 : mem_rdata;
   assign proto_set = (mem_ack && (state != BUSY)) ||
                      ((state == IDLE) && ex_rd_req && ex_wr_req);

   // Grant latching, streak/timeout counters and response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rid        <= FETCH;
         streak     <= '0;
         tcnt       <= '0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         last_grant <= 1'b0;
         if_data    <= '0;
         ex_rdata   <= '0;
      end else begin
         if (take_grant) begin
            tcnt       <= '0;
            mem_we     <= grant[GNT_STORE];
            mem_wdata  <= ex_wdata;
            mem_addr   <= grant[GNT_FETCH] ? if_addr : ex_addr;
            last_grant <= ~grant[GNT_FETCH];
            if (grant[GNT_STORE])     rid <= STORE;
            else if (grant[GNT_LOAD]) rid <= LOAD;
            else                      rid <= FETCH;
            if (grant[GNT_FETCH] || !if_req) streak <= '0;
            else if (!streak_full)           streak <= streak + 1'b1;
         end else if (state == BUSY) begin
            tcnt <= tcnt + 1'b1;
         end
         if (finish || abort) begin
            if (rid == FETCH)     if_data  <= rsp_data;
            else if (rid == LOAD) ex_rdata <= rsp_data;
         end
      end
   end

   // Status bits; a coincident set overrides status_clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_err   <= 1'b0;
         proto_err <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         bus_err   <= abort | (bus_err & ~status_clr);
         proto_err <= proto_set | (proto_err & ~status_clr);
         err_pulse <= abort;
      end
   end

   assign mem_req        = (state == BUSY);
   assign busy           = (state != IDLE);
   assign if_ack         = (state == DONE) && (rid == FETCH);
   assign ex_value_ready = (state == DONE) && (rid == LOAD);
   assign ex_wr_done     = (state == DONE) && (rid == STORE);

   always_comb begin
      status                = '0;
      status[ST_BUS_ERR]    = bus_err;
      status[ST_PROTO_ERR]  = proto_err;
      status[ST_LAST_GRANT] = last_grant;
      status[ST_ERR_PULSE]  = err_pulse;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory port between the fetch stage (instruction reads) and the execute/store-back stage (LOAD/STORE). It serialises one transaction at a time and prefers execute, with a bounded anti-starvation rule for fetch. It returns per-requester completion pulses (`if_ack`, `ex_value_ready`, `ex_wr_done`) and reports bus timeouts and protocol errors in a sticky status word.

## Interface
Parameters:
- `AW`, 8: memory address width.
- `DW`, 16: data width.
- `TIMEOUT`, 15: number of BUSY cycles without `mem_ack` before the transaction is aborted.
- `MAX_STREAK`, 3: consecutive execute grants allowed while fetch is waiting.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch read request, level; held until `if_ack`.
- `if_addr`  in  AW  fetch address.
- `if_data`  out  DW  fetch read data; valid while `if_ack`=1.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `ex_rd_req`  in  1  execute LOAD request, level.
- `ex_wr_req`  in  1  execute STORE request, level.
- `ex_addr`  in  AW  execute address.
- `ex_wdata`  in  DW  STORE data.
- `ex_rdata`  out  DW  LOAD data; valid while `ex_value_ready`=1.
- `ex_value_ready`  out  1  one-cycle LOAD completion pulse.
- `ex_wr_done`  out  1  one-cycle STORE completion pulse.
- `mem_req`  out  1  memory request, held until `mem_ack` or timeout.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory completion, one cycle.
- `status_clr`  in  1  synchronous clear of the sticky status bits.
- `busy`  out  1  1 when state ≠ IDLE.
- `status`  out  4  [3] `bus_err` (sticky), [2] `proto_err` (sticky), [1] `last_grant` (1 = execute), [0] `err_pulse` (aborted transaction this response).

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Sample requests at each edge.
  - Grant order: STORE > LOAD > fetch.
  - Exception: fetch is granted when `if_req`=1 and `streak`==`MAX_STREAK`.
  - On a grant, latch requester id, `mem_addr`, `mem_we`, `mem_wdata`; set `mem_req`=1; go to BUSY.
- **Streak counter** (width `$clog2(MAX_STREAK+1)`):
  - +1 on an execute grant while `if_req`=1.
  - Cleared on a fetch grant, or on an execute grant with `if_req`=0.
  - Saturates at `MAX_STREAK`.
- **BUSY**
  - Timeout counter starts at 0 and increments each cycle.
  - On `mem_ack`: capture `mem_rdata` into the requester's data register, drop `mem_req`, go to DONE.
  - On counter == `TIMEOUT`-1 without `mem_ack`: drop `mem_req`, set `bus_err`, set `err_pulse`, force the data register to 0, go to DONE.
- **DONE**
  - Assert exactly one of `if_ack` / `ex_value_ready` / `ex_wr_done` for this one cycle, then go to IDLE.
  - Requests are not sampled in DONE.
  - The requester must drop its request at the edge ending DONE.
- **`ex_rd_req` and `ex_wr_req` both high in IDLE:** service the STORE and set `proto_err`.
- **`mem_ack` while not in BUSY:** ignored; set `proto_err`.
- **`status_clr`** clears bits [3:2]. If clear and set coincide, set wins.
- Data outputs (`if_data`, `ex_rdata`) hold their last value outside the ack pulse.

## Timing
- Reset (async): state IDLE, all outputs 0, streak counter 0, timeout counter 0. A reset during BUSY drops `mem_req` immediately; no completion pulse is issued.
- Request high before edge E0 → `mem_req`, `mem_addr`, `mem_we` registered high after E0.
- `mem_ack` sampled at edge Ek → completion pulse and data valid for the cycle after Ek.
- Minimum latency, request to ack pulse: 2 cycles (memory acks in the first BUSY cycle).
- Back-to-back throughput: one transaction per (memory latency + 2) cycles. The next grant is sampled at the edge ending DONE+1 (IDLE).
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then DONE.
- `mem_addr`, `mem_we`, `mem_wdata` are stable for the whole of BUSY.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum (IDLE/BUSY/DONE).
  - `req_id_t` enum (FETCH/LOAD/STORE).
  - Status bit index constants `ST_BUS_ERR`=3, `ST_PROTO_ERR`=2, `ST_LAST_GRANT`=1, `ST_ERR_PULSE`=0.
- Sub-module `mem_arb_pick`:
  - Combinational priority plus streak override.
  - Inputs: three requests and `streak_full`. Output: one-hot grant.
  - The FSM, counters and registers stay in the top module.

## Test plan
- **Single LOAD:** `ex_rd_req`=1, `ex_addr`=8'h20, memory acks after 1 cycle with 16'h1234 → `mem_we`=0, `mem_addr`=8'h20; `ex_value_ready` pulses 1 cycle with `ex_rdata`=16'h1234, 2 cycles after request.
- **Single STORE:** `ex_wr_req`=1, `ex_addr`=8'h05, `ex_wdata`=16'hBEEF → `mem_we`=1, `mem_wdata`=16'hBEEF; one `ex_wr_done` pulse; `if_ack` stays 0.
- **Starvation:** `if_req` held high while execute requests continuously → grants are exactly 3 execute, 1 fetch, repeating; `status[1]` tracks each grant.
- **Timeout:** memory never acks → `mem_req` high 15 cycles, then `if_ack` pulse with `if_data`=0; `status[3]`=1 until `status_clr`.
- **Protocol errors:** `ex_rd_req` and `ex_wr_req` both high → write performed, `status[2]`=1. Stray `mem_ack` in IDLE → `status[2]`=1 and no pulse.
- **Reset mid-BUSY:** `rst` asserted two cycles into a LOAD → `mem_req`=0 asynchronously, no `ex_value_ready`. After release, a fresh LOAD completes normally.
